// File: rtl/adder_seq.sv
// Multi-cycle ripple adder: adds one BW_CHUNK-bit slice per clock, LSB first,
// with valid/ready handshakes on the operand and result sides.
module adder_seq #(
  parameter int unsigned BW_DATA  = 32,
  parameter int unsigned BW_CHUNK = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [BW_DATA-1:0] i_a,
  input  logic [BW_DATA-1:0] i_b,
  input  logic               i_cin,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [BW_DATA-1:0] o_sum,
  output logic               o_cout,
  output logic               o_ovf
);

  localparam int unsigned N_CHUNK = BW_DATA / BW_CHUNK;
  localparam int unsigned IDX_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if ((BW_DATA % BW_CHUNK) != 0) begin : g_bad_cfg
    $error("adder_seq: BW_DATA must be a multiple of BW_CHUNK");
  end

  logic [1:0]         state_q, state_d;
  logic [BW_DATA-1:0] a_q, a_d;
  logic [BW_DATA-1:0] b_q, b_d;
  logic [BW_DATA-1:0] acc_q, acc_d;
  logic [BW_DATA-1:0] sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;

  logic [BW_CHUNK:0]  slice_c;
  logic [BW_DATA-1:0] acc_next_c;

  // Operands shift right each CALC cycle, so the active slice is always the low chunk
  // and on the last cycle its top bit is the operand MSB.
  always_comb begin
    slice_c    = {1'b0, a_q[BW_CHUNK-1:0]} + {1'b0, b_q[BW_CHUNK-1:0]}
               + (BW_CHUNK+1)'(carry_q);
    acc_next_c = (acc_q >> BW_CHUNK)
               | (BW_DATA'(slice_c[BW_CHUNK-1:0]) << (BW_DATA - BW_CHUNK));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d     = i_a;
          b_d     = i_b;
          carry_d = i_cin;
          idx_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d   = acc_next_c;
        a_d     = a_q >> BW_CHUNK;
        b_d     = b_q >> BW_CHUNK;
        carry_d = slice_c[BW_CHUNK];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          sum_d   = acc_next_c;
          cout_d  = slice_c[BW_CHUNK];
          ovf_d   = (a_q[BW_CHUNK-1] == b_q[BW_CHUNK-1])
                 && (slice_c[BW_CHUNK-1] != a_q[BW_CHUNK-1]);
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_cout  = cout_q;
  assign o_ovf   = ovf_q;

endmodule
